// File: rtl/serial_deser.sv
// rtl/serial_deser.sv - serial-to-parallel receiver, LSB first, with one-word holding buffer
// Collects SI bits under SV into WIDTH-bit words; SF restarts a frame at bit 0.
module serial_deser #(
  parameter int WIDTH = 4
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             SI,
  input  logic             SV,
  input  logic             SF,
  input  logic             QR,
  output logic [WIDTH-1:0] Q,
  output logic             QV,
  output logic             BUSY,
  output logic             OVF
);

  localparam int CW = $clog2(WIDTH + 1);

  typedef enum logic {
    IDLE,
    SHIFT
  } state_t;

  state_t            state;
  // sh[0] would never be read: the last bit comes straight from SI
  logic [WIDTH-1:1]  sh;
  logic [CW-1:0]     cnt;

  logic [WIDTH-1:0]  word;
  logic [WIDTH-1:1]  sf_load;
  logic              complete;
  logic              free;
  logic              take;

  always_comb begin
    word              = {SI, sh};
    sf_load           = '0;
    sf_load[WIDTH-1]  = SI;
    complete          = SV && !SF && (cnt == CW'(WIDTH - 1));
    free              = !QV || QR;
    take              = QV && QR;
  end

  assign BUSY = (cnt != '0);

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      Q     <= '0;
      QV    <= 1'b0;
      OVF   <= 1'b0;
    end else if (clr) begin
      state <= IDLE;
      sh    <= '0;
      cnt   <= '0;
      Q     <= '0;
      QV    <= 1'b0;
      OVF   <= 1'b0;
    end else begin
      if (SV) begin
        if (SF) begin
          sh    <= sf_load;
          cnt   <= CW'(1);
          state <= SHIFT;
        end else if (complete) begin
          sh    <= word[WIDTH-1:1];
          cnt   <= '0;
          state <= IDLE;
        end else begin
          sh    <= word[WIDTH-1:1];
          cnt   <= cnt + CW'(1);
          state <= SHIFT;
        end
      end

      // a completing word either lands in the buffer or is dropped
      if (complete && free) begin
        Q  <= word;
        QV <= 1'b1;
      end else if (complete) begin
        OVF <= 1'b1;
      end else if (take) begin
        QV <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_serial_deser.sv
// tb/tb_serial_deser.sv - self-checking bench for serial_deser (WIDTH=4)
module tb_serial_deser;

  logic       clk;
  logic       rst;
  logic       clr;
  logic       SI;
  logic       SV;
  logic       SF;
  logic       QR;
  logic [3:0] Q;
  logic       QV;
  logic       BUSY;
  logic       OVF;

  int n_checks;
  int n_fail;
  logic [3:0] sb_q[$];
  logic [3:0] exp_w;

  serial_deser #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .clr (clr),
    .SI  (SI),
    .SV  (SV),
    .SF  (SF),
    .QR  (QR),
    .Q   (Q),
    .QV  (QV),
    .BUSY(BUSY),
    .OVF (OVF)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // inputs change 1 time unit after a rising edge; outputs are sampled there too
  task automatic step(input logic si, input logic sv, input logic sf, input logic qr);
    SI = si;
    SV = sv;
    SF = sf;
    QR = qr;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    logic [3:0] w;
    rst = 1'b0;
    clr = 1'b0;
    for (int i = 0; i < 2; i++) begin
      step(1'b1, i[0], 1'b0, 1'b0);
      n_checks++;
      if (Q !== 4'b0000 || QV !== 1'b0 || OVF !== 1'b0 || BUSY !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_state: Q=%b QV=%b OVF=%b BUSY=%b required 0000 0 0 0", Q, QV, OVF, BUSY);
      end
    end
    rst = 1'b1;
    w = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sb_q.push_back(w);
      step(w[i], 1'b1, 1'b0, 1'b0);
      if (i < 3) begin
        n_checks++;
        if (BUSY !== 1'b1 || QV !== 1'b0) begin
          n_fail++;
          $display("FAIL reset_busy_edge%0d: BUSY=%b QV=%b required 1 0", i + 1, BUSY, QV);
        end
      end
    end
    exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : 4'bxxxx;
    n_checks++;
    if (Q !== exp_w || QV !== 1'b1 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL first_word: Q=%b QV=%b BUSY=%b required %b 1 0", Q, QV, BUSY, exp_w);
    end
  endtask

  task automatic test_gaps;
    logic [3:0] w;
    step(1'bx, 1'b0, 1'bx, 1'b1);
    n_checks++;
    if (QV !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_consume: QV=%b required 0", QV);
    end
    w = 4'b1101;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sb_q.push_back(w);
      step(w[i], 1'b1, 1'b0, 1'b0);
      if (i < 3) begin
        step(1'bx, 1'b0, 1'bx, 1'b0);
        n_checks++;
        if (QV !== 1'b0 || BUSY !== 1'b1 || $isunknown(dut.cnt)) begin
          n_fail++;
          $display("FAIL gaps_hold%0d: QV=%b BUSY=%b cnt=%b required 0 1 known", i, QV, BUSY, dut.cnt);
        end
      end
    end
    exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : 4'bxxxx;
    n_checks++;
    if (Q !== exp_w || QV !== 1'b1) begin
      n_fail++;
      $display("FAIL gaps_word: Q=%b QV=%b required %b 1", Q, QV, exp_w);
    end
    for (int i = 0; i < 2; i++) step(1'bx, 1'b0, 1'bx, 1'b0);
    n_checks++;
    if (Q !== exp_w || QV !== 1'b1 || $isunknown(Q) || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_no_x: Q=%b QV=%b BUSY=%b required %b 1 0", Q, QV, BUSY, exp_w);
    end
    step(1'bx, 1'b0, 1'bx, 1'b1);
    step(1'bx, 1'b0, 1'bx, 1'b0);
    n_checks++;
    if (QV !== 1'b0) begin
      n_fail++;
      $display("FAIL gaps_once: QV=%b required 0", QV);
    end
  endtask

  task automatic test_back_to_back;
    logic [3:0] w0;
    logic [3:0] w1;
    w0 = 4'b0110;
    w1 = 4'b1011;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sb_q.push_back(w0);
      step(w0[i], 1'b1, 1'b0, 1'b0);
    end
    exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : 4'bxxxx;
    n_checks++;
    if (Q !== exp_w || QV !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_word0: Q=%b QV=%b required %b 1", Q, QV, exp_w);
    end
    // consume the held word on the very edge the next one completes
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sb_q.push_back(w1);
      step(w1[i], 1'b1, 1'b0, (i == 3));
      if (i < 3) begin
        n_checks++;
        if (QV !== 1'b1) begin
          n_fail++;
          $display("FAIL b2b_qv_hold%0d: QV=%b required 1", i, QV);
        end
      end
    end
    exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : 4'bxxxx;
    n_checks++;
    if (Q !== exp_w || QV !== 1'b1 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL b2b_word1: Q=%b QV=%b OVF=%b required %b 1 0", Q, QV, OVF, exp_w);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (QV !== 1'b0 || Q !== exp_w) begin
      n_fail++;
      $display("FAIL b2b_consume: Q=%b QV=%b required %b 0", Q, QV, exp_w);
    end
  endtask

  task automatic test_overflow;
    logic [3:0] w0;
    logic [3:0] w1;
    w0 = 4'b1101;
    w1 = 4'b1110;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sb_q.push_back(w0);
      step(w0[i], 1'b1, 1'b0, 1'b0);
    end
    for (int i = 0; i < 4; i++) step(w1[i], 1'b1, 1'b0, 1'b0);
    exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : 4'bxxxx;
    n_checks++;
    if (Q !== exp_w || QV !== 1'b1 || OVF !== 1'b1) begin
      n_fail++;
      $display("FAIL ovf_drop: Q=%b QV=%b OVF=%b required %b 1 1", Q, QV, OVF, exp_w);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
    n_checks++;
    if (QV !== 1'b0 || OVF !== 1'b1 || Q !== exp_w) begin
      n_fail++;
      $display("FAIL ovf_sticky: Q=%b QV=%b OVF=%b required %b 0 1", Q, QV, OVF, exp_w);
    end
    QR = 1'b0;
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    n_checks++;
    if (OVF !== 1'b0 || QV !== 1'b0 || Q !== 4'b0000 || BUSY !== 1'b0) begin
      n_fail++;
      $display("FAIL ovf_clr: Q=%b QV=%b OVF=%b BUSY=%b required 0000 0 0 0", Q, QV, OVF, BUSY);
    end
  endtask

  task automatic test_resync;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL resync_busy: BUSY=%b required 1", BUSY);
    end
    step(1'b0, 1'b1, 1'b1, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    n_checks++;
    if (QV !== 1'b0 || BUSY !== 1'b1) begin
      n_fail++;
      $display("FAIL resync_partial: QV=%b BUSY=%b required 0 1", QV, BUSY);
    end
    sb_q.push_back(4'b1110);
    step(1'b1, 1'b1, 1'b0, 1'b0);
    exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : 4'bxxxx;
    n_checks++;
    if (Q !== exp_w || QV !== 1'b1 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL resync_word: Q=%b QV=%b OVF=%b required %b 1 0", Q, QV, OVF, exp_w);
    end
    step(1'b0, 1'b0, 1'b0, 1'b1);
  endtask

  task automatic test_reset_midframe;
    logic [3:0] w;
    step(1'b1, 1'b1, 1'b0, 1'b0);
    step(1'b0, 1'b1, 1'b0, 1'b0);
    #2;
    rst = 1'b0;
    #1;
    n_checks++;
    if (Q !== 4'b0000 || QV !== 1'b0 || BUSY !== 1'b0 || OVF !== 1'b0) begin
      n_fail++;
      $display("FAIL midframe_async: Q=%b QV=%b BUSY=%b OVF=%b required 0000 0 0 0", Q, QV, BUSY, OVF);
    end
    @(posedge clk);
    #1;
    rst = 1'b1;
    w = 4'b0111;
    for (int i = 0; i < 4; i++) begin
      if (i == 3) sb_q.push_back(w);
      step(w[i], 1'b1, 1'b0, 1'b0);
      if (i == 1) begin
        n_checks++;
        if (QV !== 1'b0) begin
          n_fail++;
          $display("FAIL midframe_no_spurious: QV=%b required 0", QV);
        end
      end
    end
    exp_w = (sb_q.size() > 0) ? sb_q.pop_front() : 4'bxxxx;
    n_checks++;
    if (Q !== exp_w || QV !== 1'b1) begin
      n_fail++;
      $display("FAIL midframe_word: Q=%b QV=%b required %b 1", Q, QV, exp_w);
    end
  endtask

  initial begin
    n_checks = 0;
    n_fail   = 0;
    rst = 1'b0;
    clr = 1'b0;
    SI  = 1'b0;
    SV  = 1'b0;
    SF  = 1'b0;
    QR  = 1'b0;
    test_reset();
    test_gaps();
    test_back_to_back();
    test_overflow();
    test_resync();
    test_reset_midframe();
    n_checks++;
    if (sb_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: %0d words left, required 0", sb_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
